// File: rtl/inst_rom_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : inst_rom_arbiter_if
// Description : Bus bundle for the instruction-ROM arbiter. It carries the
//               fetch port, the debug port and the shared ROM read port.
//               The arbiter connects through the slave modport. The
//               requesters and the ROM connect through the master modport.
// Revision    : 1.0  initial release
// ============================================================================
interface inst_rom_arbiter_if;
    // Fetch requester
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_gnt;
    logic        fetch_valid;
    logic [31:0] fetch_data;
    logic        fetch_err;

    // Debug / monitor requester
    logic        dbg_req;
    logic [31:0] dbg_addr;
    logic        dbg_gnt;
    logic        dbg_valid;
    logic [31:0] dbg_data;
    logic        dbg_err;

    // Shared combinational ROM read port
    logic [31:0] rom_addr;
    logic [31:0] rom_data;

    // Arbiter side
    modport slave (
        input  fetch_req, fetch_addr, dbg_req, dbg_addr, rom_data,
        output fetch_gnt, fetch_valid, fetch_data, fetch_err,
        output dbg_gnt, dbg_valid, dbg_data, dbg_err, rom_addr
    );

    // Requester and ROM side
    modport master (
        output fetch_req, fetch_addr, dbg_req, dbg_addr, rom_data,
        input  fetch_gnt, fetch_valid, fetch_data, fetch_err,
        input  dbg_gnt, dbg_valid, dbg_data, dbg_err, rom_addr
    );
endinterface
`default_nettype wire

// File: rtl/inst_rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : inst_rom_arbiter
// Description : Shares the single combinational instruction-ROM read port
//               between the fetch stage and a debug port. Fetch has priority.
//               A starvation counter forces a debug grant after STARVE_LIMIT
//               consecutive waiting cycles. The ROM word is registered into
//               the granted port's response one cycle after the grant.
// Options     : INST_ARB_RANGE_CHECK_EN - when defined, a misaligned or
//               out-of-range address returns err=1 with data=0. When it is
//               not defined, the error flags stay 0 and the ROM aliases the
//               upper address bits.
// Revision    : 1.0  initial release
// ============================================================================
module inst_rom_arbiter #(
    parameter int ADDR_WIDTH   = 5,
    parameter int STARVE_LIMIT = 4
) (
    input  wire                  clock,
    input  wire                  reset,
    inst_rom_arbiter_if.slave    bus
);

    localparam logic [3:0] c_starve_limit = 4'(STARVE_LIMIT);

    // Reject parameter values that the address slicing or the 4-bit counter cannot support
    generate
        if (ADDR_WIDTH < 1 || ADDR_WIDTH > 29 || STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_param_check
            $error("inst_rom_arbiter: illegal ADDR_WIDTH or STARVE_LIMIT");
        end
    endgenerate

    logic [3:0]  r_dbg_wait;
    logic        w_force_dbg;
    logic        w_fetch_gnt;
    logic        w_dbg_gnt;
    logic [31:0] w_rom_addr;
    logic        w_fetch_bad;
    logic        w_dbg_bad;

    logic        r_fetch_valid;
    logic [31:0] r_fetch_data;
    logic        r_fetch_err;
    logic        r_dbg_valid;
    logic [31:0] r_dbg_data;
    logic        r_dbg_err;

    // Address checking. The flags are constant 0 when checking is compiled out.
`ifdef INST_ARB_RANGE_CHECK_EN
    assign w_fetch_bad = (bus.fetch_addr[1:0] != 2'b00) ||
                         (bus.fetch_addr[31:ADDR_WIDTH+2] != '0);
    assign w_dbg_bad   = (bus.dbg_addr[1:0] != 2'b00) ||
                         (bus.dbg_addr[31:ADDR_WIDTH+2] != '0);
`else
    assign w_fetch_bad = 1'b0;
    assign w_dbg_bad   = 1'b0;
`endif

    assign w_force_dbg = (r_dbg_wait == c_starve_limit);

    // Grant decision and ROM address mux; everything is held idle while in reset
    always_comb begin
        w_fetch_gnt = 1'b0;
        w_dbg_gnt   = 1'b0;
        w_rom_addr  = 32'd0;
        if (!reset) begin
            if (bus.fetch_req && !(bus.dbg_req && w_force_dbg)) begin
                w_fetch_gnt = 1'b1;
                w_rom_addr  = bus.fetch_addr;
            end else if (bus.dbg_req) begin
                w_dbg_gnt   = 1'b1;
                w_rom_addr  = bus.dbg_addr;
            end
        end
    end

    // Starvation counter: counts cycles that debug waits, saturating at the limit
    always_ff @(posedge clock) begin
        if (reset) begin
            r_dbg_wait <= 4'd0;
        end else if (!bus.dbg_req || w_dbg_gnt) begin
            r_dbg_wait <= 4'd0;
        end else if (r_dbg_wait < c_starve_limit) begin
            r_dbg_wait <= r_dbg_wait + 4'd1;
        end
    end

    // Fetch response register: loads only on a fetch grant and holds otherwise
    always_ff @(posedge clock) begin
        if (reset) begin
            r_fetch_valid <= 1'b0;
            r_fetch_data  <= 32'd0;
            r_fetch_err   <= 1'b0;
        end else begin
            r_fetch_valid <= w_fetch_gnt;
            if (w_fetch_gnt) begin
                r_fetch_data <= w_fetch_bad ? 32'd0 : bus.rom_data;
                r_fetch_err  <= w_fetch_bad;
            end
        end
    end

    // Debug response register: loads only on a debug grant and holds otherwise
    always_ff @(posedge clock) begin
        if (reset) begin
            r_dbg_valid <= 1'b0;
            r_dbg_data  <= 32'd0;
            r_dbg_err   <= 1'b0;
        end else begin
            r_dbg_valid <= w_dbg_gnt;
            if (w_dbg_gnt) begin
                r_dbg_data <= w_dbg_bad ? 32'd0 : bus.rom_data;
                r_dbg_err  <= w_dbg_bad;
            end
        end
    end

    assign bus.fetch_gnt   = w_fetch_gnt;
    assign bus.dbg_gnt     = w_dbg_gnt;
    assign bus.rom_addr    = w_rom_addr;
    assign bus.fetch_valid = r_fetch_valid;
    assign bus.fetch_data  = r_fetch_data;
    assign bus.fetch_err   = r_fetch_err;
    assign bus.dbg_valid   = r_dbg_valid;
    assign bus.dbg_data    = r_dbg_data;
    assign bus.dbg_err     = r_dbg_err;

endmodule
`default_nettype wire
